// File: rtl/fixed_point_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_divider_scheduler
// Description : Round-robin arbiter sharing one iterative fixed-point divider
//               core among NUM_REQ requesters, with divide-by-zero bypass and
//               a start-to-done timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_divider_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int FRAC_W      = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
    input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_quotient,
    output logic                      resp_dbz,
    output logic                      resp_timeout,
    output logic                      div_start,
    output logic [DATA_W-1:0]         div_dividend,
    output logic [DATA_W-1:0]         div_divisor,
    input  logic                      div_busy,
    input  logic                      div_done,
    input  logic [DATA_W-1:0]         div_quotient
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_PW    = c_IDX_W + 1;
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [c_PW-1:0]    c_NUM  = c_PW'(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_TMAX = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] c_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || FRAC_W > DATA_W) begin : g_bad_param
            $error("fixed_point_divider_scheduler: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_gnt;
    logic [DATA_W-1:0]    r_dividend;
    logic [DATA_W-1:0]    r_divisor;
    logic [DATA_W-1:0]    r_quot;
    logic                 r_dbz;
    logic                 r_timeout;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_found;
    logic                 w_go;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_PW-1:0]      w_pos;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic                 w_hs;
    logic                 w_hit;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_pos   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = {1'b0, r_ptr} + c_PW'(i);
            if (w_pos >= c_NUM) begin
                w_pos = w_pos - c_NUM;
            end
            if (req_valid[w_pos[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[c_IDX_W-1:0];
            end
        end
    end

    assign w_go     = w_found & ~div_busy;
    assign w_gnt_oh = c_ONE << r_gnt;
    assign w_hs     = resp_ready[r_gnt];
    assign w_hit    = (r_cnt == c_TMAX);

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign resp_quotient = r_quot;
    assign resp_dbz      = r_dbz;
    assign resp_timeout  = r_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        div_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_ready = w_gnt_oh;
                if (r_divisor == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    div_start   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_done || w_hit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = w_gnt_oh;
                if (w_hs) begin
                    // A timed-out core may still be busy; let it finish first.
                    w_state_nxt = r_timeout ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!div_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_gnt      <= w_idx;
                        r_dividend <= req_dividend[w_idx*DATA_W +: DATA_W];
                        r_divisor  <= req_divisor[w_idx*DATA_W +: DATA_W];
                        r_cnt      <= '0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_divisor == '0) begin
                        r_quot <= '1;
                        r_dbz  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (div_done) begin
                        r_quot <= div_quotient;
                    end else if (w_hit) begin
                        r_quot    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_hs) begin
                        r_dbz     <= 1'b0;
                        r_timeout <= 1'b0;
                        r_ptr     <= (r_gnt == c_LAST) ? '0 : r_gnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_point_divider_scheduler
// Description : Directed self-checking bench with a behavioural divider core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_point_divider_scheduler;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic [3:0]  req_valid    = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_dividend = '0;
    logic [31:0] req_divisor  = '0;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready   = '0;
    logic [7:0]  resp_quotient;
    logic        resp_dbz;
    logic        resp_timeout;
    logic        div_start;
    logic [7:0]  div_dividend;
    logic [7:0]  div_divisor;
    logic        div_busy     = 1'b0;
    logic        div_done     = 1'b0;
    logic [7:0]  div_quotient = '0;

    int checks = 0;
    int errors = 0;

    // Behavioural core: 3-cycle latency, or stuck busy until released.
    bit          core_stuck   = 1'b0;
    bit          core_release = 1'b0;
    logic [7:0]  core_a       = '0;
    logic [7:0]  core_b       = 8'd1;
    logic [2:0]  core_cnt     = '0;
    logic [11:0] core_q;

    assign core_q = {core_a, 4'h0} / {4'h0, core_b};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (core_release) begin
            div_busy     <= 1'b0;
            div_done     <= 1'b1;
            div_quotient <= 8'hAA;
        end else if (div_start) begin
            div_busy <= 1'b1;
            core_cnt <= 3'd3;
            core_a   <= div_dividend;
            core_b   <= div_divisor;
        end else if (div_busy && !core_stuck) begin
            if (core_cnt == 3'd1) begin
                div_busy     <= 1'b0;
                div_done     <= 1'b1;
                div_quotient <= core_q[7:0];
            end else begin
                core_cnt <= core_cnt - 3'd1;
            end
        end
    end

    fixed_point_divider_scheduler #(
        .NUM_REQ    (4),
        .DATA_W     (8),
        .FRAC_W     (4),
        .TIMEOUT_CYC(64)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_quotient(resp_quotient),
        .resp_dbz     (resp_dbz),
        .resp_timeout (resp_timeout),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_busy     (div_busy),
        .div_done     (div_done),
        .div_quotient (div_quotient)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int g);
        logic [3:0] v;
        v = 4'b0001 << g;
        return v;
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_dividend[i*8 +: 8] = a;
        req_divisor[i*8 +: 8]  = b;
    endtask

    // Called at a negedge while the scheduler is idle; returns in the ISSUE cycle.
    task automatic issue_one(input int g, input logic [7:0] a, input logic [7:0] b,
                             input string tag);
        int n;
        n = 0;
        set_ops(g, a, b);
        req_valid[g] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        check({tag, "_acc"}, req_ready, oh(g));
        req_valid[g] = 1'b0;
    endtask

    task automatic expect_resp(input int g, input logic [7:0] q, input logic dbz,
                               input logic tmo, input int hold, input string tag);
        int n;
        n = 0;
        while (resp_valid == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_v"}, resp_valid, oh(g));
        check({tag, "_q"}, resp_quotient, q);
        check({tag, "_flags"}, {resp_dbz, resp_timeout}, {dbz, tmo});
        for (int k = 0; k < hold; k++) begin
            resp_ready = ~oh(g);
            @(negedge clk);
            check({tag, "_hold_v"}, resp_valid, oh(g));
            check({tag, "_hold_q"}, resp_quotient, q);
            check({tag, "_hold_rdy"}, req_ready, 4'b0000);
        end
        resp_ready = oh(g);
        @(negedge clk);
        resp_ready = '0;
        check({tag, "_ack"}, resp_valid, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_quot", resp_quotient, 8'h00);
        check("rst_flags", {resp_dbz, resp_timeout}, 2'b00);
        check("rst_start", div_start, 1'b0);
        check("rst_ops", {div_dividend, div_divisor}, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk);

        // 3.0 / 2.0 = 1.5
        issue_one(0, 8'h30, 8'h20, "single");
        check("single_start", div_start, 1'b1);
        check("single_opa", div_dividend, 8'h30);
        check("single_opb", div_divisor, 8'h20);
        expect_resp(0, 8'h18, 1'b0, 1'b0, 0, "single");

        // Divide-by-zero: bypasses the core, response two cycles after grant.
        set_ops(2, 8'h40, 8'h00);
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("dbz_acc", req_ready, 4'b0100);
        check("dbz_start", div_start, 1'b0);
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("dbz_lat", resp_valid, 4'b0100);
        expect_resp(2, 8'hFF, 1'b1, 1'b0, 0, "dbz");

        // Backpressure with a competing requester and foreign resp_ready bits.
        issue_one(3, 8'h50, 8'h10, "bp");
        req_valid = 4'b0010;
        expect_resp(3, 8'h50, 1'b0, 1'b0, 10, "bp");
        req_valid = 4'b0000;

        // Round robin, pointer back at 0.
        for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h10 * (i + 1)), 8'h10);
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++)
            expect_resp(i, 8'(8'h10 * (i + 1)), 1'b0, 1'b0, 0, $sformatf("rr%0d", i));
        req_valid = 4'b1001;
        expect_resp(0, 8'h10, 1'b0, 1'b0, 0, "rr9_a");
        expect_resp(3, 8'h40, 1'b0, 1'b0, 0, "rr9_b");
        expect_resp(0, 8'h10, 1'b0, 1'b0, 0, "rr9_c");
        req_valid = 4'b0000;

        // Timeout: stuck core, response 64 cycles after start, then drain.
        core_stuck = 1'b1;
        set_ops(1, 8'h20, 8'h10);
        req_valid[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_start && n < 50);
        check("to_start", div_start, 1'b1);
        req_valid[1] = 1'b0;
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_lat", n, 64);
        expect_resp(1, 8'h00, 1'b0, 1'b1, 0, "to");
        set_ops(0, 8'h30, 8'h20);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("drain_rdy", req_ready, 4'b0000);
        end
        core_stuck   = 1'b0;
        core_release = 1'b1;
        @(negedge clk);
        core_release = 1'b0;
        issue_one(0, 8'h30, 8'h20, "post");
        expect_resp(0, 8'h18, 1'b0, 1'b0, 0, "post");

        // Asynchronous reset while waiting on the core.
        core_stuck = 1'b1;
        issue_one(2, 8'h40, 8'h10, "ar");
        repeat (3) @(negedge clk);
        check("ar_pre_opa", div_dividend, 8'h40);
        #2 reset_n = 1'b0;
        #1;
        check("ar_ops", {div_dividend, div_divisor}, 16'h0000);
        check("ar_quot", resp_quotient, 8'h00);
        check("ar_valid", {req_ready, resp_valid}, 8'h00);
        check("ar_start", div_start, 1'b0);
        @(negedge clk);
        reset_n      = 1'b1;
        core_stuck   = 1'b0;
        core_release = 1'b1;
        @(negedge clk);
        core_release = 1'b0;
        repeat (2) @(negedge clk);
        set_ops(0, 8'h10, 8'h10);
        set_ops(2, 8'h40, 8'h10);
        req_valid = 4'b0101;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        check("ar_ptr", req_ready, 4'b0001);
        req_valid = 4'b0000;
        expect_resp(0, 8'h10, 1'b0, 1'b0, 0, "ar_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
